vga_timing_prog: RTL and testbench

Runtime-programmable video timing generator: the parametrised successor to the fixed-mode VGA timing cores. It produces pixel coordinates, sync, blank and frame/line strobes for any mode loaded over a configuration port. A new mode takes effect only at a frame boundary. Sync and blank are delayed by a configurable pipeline depth so they line up with the output of the downstream pixel pipeline.

---
 rtl/vga_timing_prog.sv | 162 ++++++++++++++++
 tb/tb_vga_timing_prog.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_prog.sv
// Runtime-programmable video timing generator: counters, sync/blank decode and a
// delay pipeline that lines sync/blank up with a downstream pixel pipeline.
module vga_timing_prog #(
    parameter int unsigned W     = 12,
    parameter int unsigned DELAY = 2,
    parameter int unsigned HVIS  = 1920,
    parameter int unsigned HSS   = 1976,
    parameter int unsigned HSE   = 2008,
    parameter int unsigned HTOT  = 2200,
    parameter int unsigned VVIS  = 1080,
    parameter int unsigned VSS   = 1083,
    parameter int unsigned VSE   = 1085,
    parameter int unsigned VTOT  = 1125,
    parameter logic        HPOL  = 1'b1,
    parameter logic        VPOL  = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] cfg_hvis,
    input  logic [W-1:0] cfg_hss,
    input  logic [W-1:0] cfg_hse,
    input  logic [W-1:0] cfg_htot,
    input  logic [W-1:0] cfg_vvis,
    input  logic [W-1:0] cfg_vss,
    input  logic [W-1:0] cfg_vse,
    input  logic [W-1:0] cfg_vtot,
    input  logic         cfg_hpol,
    input  logic         cfg_vpol,
    input  logic         cfg_load,
    output logic         cfg_busy,
    output logic         cfg_err,
    output logic [W-1:0] hdata,
    output logic [W-1:0] vdata,
    output logic         sol,
    output logic         sof,
    output logic         hsync,
    output logic         vsync,
    output logic         blank
);

    typedef struct packed {
        logic [W-1:0] hvis, hss, hse, htot;
        logic [W-1:0] vvis, vss, vse, vtot;
        logic         hpol, vpol;
    } cfg_t;

    localparam cfg_t CFG_RST = '{
        hvis: W'(HVIS), hss: W'(HSS), hse: W'(HSE), htot: W'(HTOT),
        vvis: W'(VVIS), vss: W'(VSS), vse: W'(VSE), vtot: W'(VTOT),
        hpol: HPOL, vpol: VPOL
    };
    localparam logic [2:0] PIPE_RST = {1'b1, ~HPOL, ~VPOL};

    cfg_t         a_q, a_d, s_q, s_d, cfg_in;
    logic         busy_q, busy_d, err_q, err_d;
    logic [W-1:0] h_q, h_d, v_q, v_d;
    logic         sol_q, sol_d, sof_q, sof_d;
    logic         cfg_valid, h_last, v_last, wrap;
    logic         vis, hs_act, vs_act;
    logic [2:0]   stage0;

    always_comb begin
        cfg_in = '{hvis: cfg_hvis, hss: cfg_hss, hse: cfg_hse, htot: cfg_htot,
                   vvis: cfg_vvis, vss: cfg_vss, vse: cfg_vse, vtot: cfg_vtot,
                   hpol: cfg_hpol, vpol: cfg_vpol};
        cfg_valid = (cfg_in.hvis != '0) && (cfg_in.hvis <= cfg_in.hss) &&
                    (cfg_in.hss < cfg_in.hse) && (cfg_in.hse <= cfg_in.htot) &&
                    (cfg_in.vvis != '0) && (cfg_in.vvis <= cfg_in.vss) &&
                    (cfg_in.vss < cfg_in.vse) && (cfg_in.vse <= cfg_in.vtot);

        h_last = (h_q == a_q.htot - W'(1));
        v_last = (v_q == a_q.vtot - W'(1));
        wrap   = en && h_last && v_last;

        h_d = h_q;
        v_d = v_q;
        if (en) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + W'(1);
            end else begin
                h_d = h_q + W'(1);
            end
        end
        sol_d = en && (h_d == '0);
        sof_d = en && (h_d == '0) && (v_d == '0);

        // The wrap consumes the shadow held before any same-cycle load; a new
        // capture then re-arms busy for the following frame.
        a_d    = (wrap && busy_q) ? s_q : a_q;
        busy_d = (wrap && busy_q) ? 1'b0 : busy_q;
        s_d    = s_q;
        err_d  = err_q;
        if (cfg_load) begin
            err_d = ~cfg_valid;
            if (cfg_valid) begin
                s_d    = cfg_in;
                busy_d = 1'b1;
            end
        end

        vis    = (h_q < a_q.hvis) && (v_q < a_q.vvis);
        hs_act = en && (h_q >= a_q.hss) && (h_q < a_q.hse);
        vs_act = en && (v_q >= a_q.vss) && (v_q < a_q.vse);
        stage0 = {~(en && vis),
                  hs_act ? a_q.hpol : ~a_q.hpol,
                  vs_act ? a_q.vpol : ~a_q.vpol};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= CFG_RST;
            s_q    <= CFG_RST;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
            sol_q  <= 1'b0;
            sof_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            s_q    <= s_d;
            busy_q <= busy_d;
            err_q  <= err_d;
            h_q    <= h_d;
            v_q    <= v_d;
            sol_q  <= sol_d;
            sof_q  <= sof_d;
        end
    end

    // Samples carry their final levels, so polarity follows the mode that decoded them.
    generate
        if (DELAY == 0) begin : g_nodelay
            assign {blank, hsync, vsync} = stage0;
        end else begin : g_delay
            genvar gi;
            for (gi = 0; gi < DELAY; gi++) begin : g_pipe
                logic [2:0] stage_q, stage_d;
                if (gi == 0) begin : g_first
                    always_comb stage_d = stage0;
                end else begin : g_next
                    always_comb stage_d = g_pipe[gi-1].stage_q;
                end
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_q <= PIPE_RST;
                    else        stage_q <= stage_d;
                end
            end
            assign {blank, hsync, vsync} = g_pipe[DELAY-1].stage_q;
        end
    endgenerate

    assign hdata    = h_q;
    assign vdata    = v_q;
    assign sol      = sol_q;
    assign sof      = sof_q;
    assign cfg_busy = busy_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_vga_timing_prog.sv
// Directed bench for vga_timing_prog; vertical reset timing is shortened so a
// default frame is only 2200x6 cycles while horizontal defaults stay 1080p.
module tb_vga_timing_prog;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [11:0] cfg_hvis, cfg_hss, cfg_hse, cfg_htot;
    logic [11:0] cfg_vvis, cfg_vss, cfg_vse, cfg_vtot;
    logic        cfg_hpol, cfg_vpol, cfg_load;
    logic        cfg_busy, cfg_err, sol, sof, hsync, vsync, blank;
    logic [11:0] hdata, vdata;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int hs_cnt, vs_cnt, bl_cnt, sof_cnt;

    always #5 clk = ~clk;

    vga_timing_prog #(
        .W(12), .DELAY(2),
        .HVIS(1920), .HSS(1976), .HSE(2008), .HTOT(2200),
        .VVIS(3), .VSS(4), .VSE(5), .VTOT(6),
        .HPOL(1'b1), .VPOL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .cfg_hvis(cfg_hvis), .cfg_hss(cfg_hss), .cfg_hse(cfg_hse), .cfg_htot(cfg_htot),
        .cfg_vvis(cfg_vvis), .cfg_vss(cfg_vss), .cfg_vse(cfg_vse), .cfg_vtot(cfg_vtot),
        .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol), .cfg_load(cfg_load),
        .cfg_busy(cfg_busy), .cfg_err(cfg_err),
        .hdata(hdata), .vdata(vdata), .sol(sol), .sof(sof),
        .hsync(hsync), .vsync(vsync), .blank(blank)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic adv_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic load_cfg(input logic [11:0] hv, hs, he, ht, vv, vs, ve, vt,
                            input logic hp, vp);
        cfg_hvis = hv; cfg_hss = hs; cfg_hse = he; cfg_htot = ht;
        cfg_vvis = vv; cfg_vss = vs; cfg_vse = ve; cfg_vtot = vt;
        cfg_hpol = hp; cfg_vpol = vp;
        cfg_load = 1'b1;
        $display("cycle %0d: cfg_load %0d/%0d/%0d/%0d x %0d/%0d/%0d/%0d pol %0d/%0d",
                 cyc, hv, hs, he, ht, vv, vs, ve, vt, hp, vp);
        tick();
        cfg_load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0;
        cfg_hvis = '0; cfg_hss = '0; cfg_hse = '0; cfg_htot = '0;
        cfg_vvis = '0; cfg_vss = '0; cfg_vse = '0; cfg_vtot = '0;
        cfg_hpol = 1'b0; cfg_vpol = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hdata", hdata, 0);
        chk("rst_vdata", vdata, 0);
        chk("rst_sof", sof, 0);
        chk("rst_blank", blank, 1);
        chk("rst_hsync", hsync, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_err", cfg_err, 0);

        // Default 1080p line timing.
        rst_n = 1'b1; en = 1'b1; cyc = 0;
        tick();
        chk("c1_hdata", hdata, 1);
        chk("c1_sol", sol, 0);
        hs_cnt = 0; bl_cnt = 0;
        while (cyc < 2200) begin
            if (hsync) hs_cnt++;
            if (!blank) bl_cnt++;
            if (cyc == 1977) chk("hsync_pre", hsync, 0);
            if (cyc == 1978) chk("hsync_lag", hsync, 1);
            tick();
        end
        chk("hsync_width", hs_cnt, 32);
        chk("visible_line0", bl_cnt, 1920);
        chk("wrap_hdata", hdata, 0);
        chk("wrap_vdata", vdata, 1);
        chk("wrap_sol", sol, 1);
        chk("wrap_sof", sof, 0);
        adv_to(4410);
        chk("line2_blank", blank, 0);
        adv_to(6610);
        chk("line3_blank", blank, 1);
        adv_to(8801);
        chk("vsync_pre", vsync, 0);
        adv_to(8802);
        chk("vsync_line4", vsync, 1);

        // Mid-frame load of an 8x5 mode with active-low syncs.
        load_cfg(4, 5, 6, 8, 2, 3, 4, 5, 0, 0);
        chk("load1_busy", cfg_busy, 1);
        chk("load1_err", cfg_err, 0);
        adv_to(13199);
        chk("prewrap_busy", cfg_busy, 1);
        chk("prewrap_hdata", hdata, 2199);
        chk("prewrap_vdata", vdata, 5);
        tick();
        chk("sw_hdata", hdata, 0);
        chk("sw_vdata", vdata, 0);
        chk("sw_sof", sof, 1);
        chk("sw_busy", cfg_busy, 0);
        tick();
        chk("sw_hdata1", hdata, 1);
        chk("sw_oldpol_hsync", hsync, 0);
        tick();
        chk("sw_newpol_hsync", hsync, 1);
        hs_cnt = 0; vs_cnt = 0; bl_cnt = 0; sof_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!hsync) hs_cnt++;
            if (!vsync) vs_cnt++;
            if (!blank) bl_cnt++;
            if (sof) sof_cnt++;
            tick();
        end
        chk("small_hsync_lows", hs_cnt, 5);
        chk("small_vsync_lows", vs_cnt, 8);
        chk("small_visible", bl_cnt, 8);
        chk("small_sof_count", sof_cnt, 1);

        // Invalid load: hss below hvis.
        load_cfg(4, 3, 6, 8, 2, 3, 4, 5, 0, 0);
        chk("bad_err", cfg_err, 1);
        chk("bad_busy", cfg_busy, 0);
        adv_to(13280);
        chk("bad_frame_h", hdata, 0);
        chk("bad_frame_v", vdata, 0);
        chk("bad_frame_sof", sof, 1);
        adv_to(13287);
        chk("bad_h7", hdata, 7);
        tick();
        chk("bad_wrap_h", hdata, 0);
        chk("bad_wrap_v", vdata, 1);

        // Two loads before a wrap: second (5-wide x 3-tall) wins.
        load_cfg(3, 4, 5, 6, 1, 2, 3, 4, 1, 1);
        chk("ok_err_clear", cfg_err, 0);
        chk("ok_busy", cfg_busy, 1);
        load_cfg(2, 3, 4, 5, 1, 2, 3, 3, 0, 1);
        chk("second_busy", cfg_busy, 1);
        adv_to(13320);
        chk("c_start_h", hdata, 0);
        chk("c_start_v", vdata, 0);
        chk("c_busy", cfg_busy, 0);
        adv_to(13325);
        chk("c_wrap_h", hdata, 0);
        chk("c_wrap_v", vdata, 1);

        // Load on the exact frame-wrap cycle applies one frame later.
        adv_to(13334);
        chk("c_last_h", hdata, 4);
        chk("c_last_v", vdata, 2);
        load_cfg(4, 5, 6, 8, 2, 3, 4, 5, 0, 0);
        chk("wl_h", hdata, 0);
        chk("wl_v", vdata, 0);
        chk("wl_busy", cfg_busy, 1);
        adv_to(13340);
        chk("wl_still_c_h", hdata, 0);
        chk("wl_still_c_v", vdata, 1);
        adv_to(13350);
        chk("d_start_h", hdata, 0);
        chk("d_busy", cfg_busy, 0);
        adv_to(13357);
        chk("d_h7", hdata, 7);
        tick();
        chk("d_wrap_h", hdata, 0);
        chk("d_wrap_v", vdata, 1);

        // en low for 10 cycles mid-line.
        adv_to(13360);
        chk("hold_start_h", hdata, 2);
        en = 1'b0;
        tick();
        chk("hold1_h", hdata, 2);
        chk("hold1_blank", blank, 0);
        tick();
        chk("hold2_blank", blank, 1);
        repeat (8) tick();
        chk("hold10_h", hdata, 2);
        chk("hold10_v", vdata, 1);
        chk("hold10_sol", sol, 0);
        chk("hold10_blank", blank, 1);
        chk("hold10_hsync", hsync, 1);
        en = 1'b1;
        tick();
        chk("resume_h", hdata, 3);
        chk("resume_blank", blank, 1);
        tick();
        chk("resume2_h", hdata, 4);
        chk("resume2_blank", blank, 0);

        // Asynchronous reset during a pending load.
        load_cfg(4, 5, 6, 8, 2, 3, 4, 5, 1, 1);
        chk("pre_rst_busy", cfg_busy, 1);
        chk("pre_rst_h", hdata, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_h", hdata, 0);
        chk("arst_v", vdata, 0);
        chk("arst_busy", cfg_busy, 0);
        chk("arst_blank", blank, 1);
        chk("arst_hsync", hsync, 0);
        chk("arst_vsync", vsync, 0);
        chk("arst_sol", sol, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1; cyc = 0;
        tick();
        chk("rs_h1", hdata, 1);
        chk("rs_v1", vdata, 0);
        adv_to(1978);
        chk("rs_hsync", hsync, 1);
        adv_to(2200);
        chk("rs_wrap_h", hdata, 0);
        chk("rs_wrap_v", vdata, 1);
        chk("rs_busy", cfg_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
